// File: rtl/multdiv_unit.sv
// Multi-cycle signed 32-bit multiply/divide: shift-add multiply and restoring divide
// over operand magnitudes, sign-corrected on completion; fixed 33-cycle latency.
module multdiv_unit (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        ctrl_busy
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [CW-1:0]   cnt;
  logic            op_mult;
  logic            sign;
  logic            b_zero;
  logic [W-1:0]    opnd;
  logic [2*W-1:0]  acc;

  logic            start;
  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  div_shift;
  logic [W:0]      div_trial;
  logic [2*W-1:0]  iter_next;
  logic [2*W-1:0]  signed_prod;
  logic [W-1:0]    quot;
  logic [W-1:0]    fin_res;
  logic            fin_exc;

  assign start = ctrl_MULT | ctrl_DIV;

  // State register
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) state <= S_IDLE;
    else               state <= state_nxt;
  end

  // Next state; a start request overrides everything, including completion
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_IDLE;
      S_RUN:  if (cnt == CW'(W - 1)) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (start) state_nxt = S_RUN;
  end

  // Operand magnitudes, one iteration step, and sign-corrected final result
  always_comb begin
    mag_a       = data_operandA[W-1] ? (~data_operandA + 32'd1) : data_operandA;
    mag_b       = data_operandB[W-1] ? (~data_operandB + 32'd1) : data_operandB;
    // multiply: acc = {partial product, remaining multiplier bits}
    mul_sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    // divide: acc = {partial remainder, dividend/quotient bits}
    div_shift   = {acc[2*W-2:0], 1'b0};
    div_trial   = {1'b0, div_shift[2*W-1:W]} - {1'b0, opnd};
    iter_next   = div_trial[W] ? div_shift : {div_trial[W-1:0], div_shift[W-1:1], 1'b1};
    if (op_mult) iter_next = {mul_sum, acc[W-1:1]};
    signed_prod = sign ? (~acc + 64'd1) : acc;
    quot        = acc[W-1:0];
    fin_res     = signed_prod[W-1:0];
    fin_exc     = signed_prod[2*W-1:W] != {W{signed_prod[W-1]}};
    if (!op_mult) begin
      // only a positive quotient of magnitude 2^31 overflows (MIN / -1)
      fin_res = b_zero ? 32'd0 : (sign ? (~quot + 32'd1) : quot);
      fin_exc = b_zero | (~sign & quot[W-1]);
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      cnt            <= '0;
      op_mult        <= 1'b0;
      sign           <= 1'b0;
      b_zero         <= 1'b0;
      opnd           <= '0;
      acc            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      ctrl_busy      <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        op_mult   <= ctrl_MULT;
        sign      <= data_operandA[W-1] ^ data_operandB[W-1];
        b_zero    <= (data_operandB == 32'd0);
        cnt       <= '0;
        opnd      <= ctrl_MULT ? mag_a : mag_b;
        acc       <= {32'd0, (ctrl_MULT ? mag_b : mag_a)};
        ctrl_busy <= 1'b1;
      end else if (state == S_RUN) begin
        acc <= iter_next;
        cnt <= cnt + 6'd1;
      end else if (state == S_DONE) begin
        data_result    <= fin_res;
        data_exception <= fin_exc;
        data_resultRDY <= 1'b1;
        ctrl_busy      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: directed cases plus randomized ops and aborts,
// checked against an arithmetic reference model by a negedge monitor.
module tb_multdiv_unit;

  typedef struct {
    logic [31:0] res;
    logic        exc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        req_mult;
  logic        req_div;
  logic [31:0] result;
  logic        exception;
  logic        result_rdy;
  logic        busy;

  int          n_total;
  int          n_pass;
  int          cyc;
  exp_t        sb[$];
  bit          op_active;
  int          op_due;
  logic [31:0] last_res;
  logic        last_exc;

  multdiv_unit dut (
    .clock         (clk),
    .ctrl_reset_n  (rst_n),
    .data_operandA (op_a),
    .data_operandB (op_b),
    .ctrl_MULT     (req_mult),
    .ctrl_DIV      (req_div),
    .data_result   (result),
    .data_exception(exception),
    .data_resultRDY(result_rdy),
    .ctrl_busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: signed arithmetic on wide integers
  function automatic exp_t model(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sb2;
    longint r;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    if (is_mult) begin
      r     = sa * sb2;
      e.res = r[31:0];
      e.exc = (r != longint'($signed(r[31:0])));
    end else if (b == 32'd0) begin
      e.res = 32'd0;
      e.exc = 1'b1;
    end else begin
      r     = sa / sb2;
      e.res = r[31:0];
      e.exc = (r != longint'($signed(r[31:0])));
    end
    return e;
  endfunction

  // Issue a start pulse; the start edge is the posedge inside this task
  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_a = a; op_b = b; req_mult = m; req_div = d;
    @(posedge clk);
    #1;
    req_mult = 1'b0; req_div = 1'b0;
    op_a = $urandom; op_b = $urandom;
    if (op_active && sb.size() > 0) void'(sb.pop_back());
    sb.push_back(model(m, a, b));
    op_active = 1'b1;
    op_due    = cyc + 33;
  endtask

  task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    start_op(m, d, a, b);
    repeat (34) @(posedge clk);
  endtask

  // Monitor: completion pulse timing, held outputs, busy window
  always @(negedge clk) begin
    bit   exp_rdy;
    exp_t e;
    if (rst_n) begin
      exp_rdy = op_active && (cyc == op_due);
      chk("rdy", 32'(result_rdy), 32'(exp_rdy));
      if (exp_rdy) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          last_res = e.res;
          last_exc = e.exc;
        end
        op_active = 1'b0;
      end
      chk("result", result, last_res);
      chk("exception", 32'(exception), 32'(last_exc));
      chk("busy", 32'(busy), 32'(op_active && (cyc < op_due)));
    end
  end

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_exception", 32'(exception), 32'd0);
    chk("rst_rdy", 32'(result_rdy), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    sb.delete();
    op_active = 1'b0;
    last_res  = 32'd0;
    last_exc  = 1'b0;
  endtask

  initial begin
    bit          m;
    bit          d;
    logic [31:0] a;
    logic [31:0] b;
    n_total = 0; n_pass = 0; cyc = 0;
    op_active = 1'b0; op_due = 0; last_res = 32'd0; last_exc = 1'b0;
    rst_n = 1'b1; req_mult = 1'b0; req_div = 1'b0; op_a = '0; op_b = '0;
    #2;
    req_mult = 1'b1;
    reset_now();
    repeat (2) @(negedge clk);
    req_mult = 1'b0;
    rst_n = 1'b1;

    // Directed cases
    run_op(1, 0, 32'd7, 32'hFFFFFFFA);
    run_op(1, 0, 32'h00010000, 32'h00010000);
    run_op(1, 0, 32'h80000000, 32'd1);
    run_op(0, 1, 32'hFFFFFFF9, 32'd2);
    run_op(0, 1, 32'd100, 32'd7);
    run_op(0, 1, 32'd5, 32'd0);
    run_op(0, 1, 32'h80000000, 32'hFFFFFFFF);
    run_op(1, 1, 32'd6, 32'd3);

    // Abort at E10, then a start coincident with completion
    start_op(1, 0, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    run_op(0, 1, 32'd20, 32'd4);
    start_op(1, 0, 32'd11, 32'd13);
    repeat (32) @(posedge clk);
    run_op(0, 1, 32'hFFFFFF00, 32'd16);

    // Reset mid-operation
    start_op(1, 0, 32'd123, 32'd456);
    repeat (15) @(posedge clk);
    #2;
    reset_now();
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1, 0, 32'd9, 32'd9);

    // Randomized operations with occasional aborts
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      d = ~m | ($urandom_range(0, 7) == 0);
      a = ($urandom_range(0, 3) == 0) ? 32'($signed(16'($urandom))) : 32'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 32'($signed(8'($urandom))) : 32'($urandom);
      if (!m && $urandom_range(0, 9) == 0) b = 32'd0;
      if ($urandom_range(0, 4) == 0) begin
        start_op(m, d, a, b);
        repeat ($urandom_range(0, 32)) @(posedge clk);
      end else begin
        run_op(m, d, a, b);
      end
    end

    repeat (36) @(negedge clk);
    chk("drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
